// File: rtl/maxpool_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_sched_if
// Brief    : Window-select and result-stream bundle between the max-pool
//            sequencer, its pool mux and the downstream buffer.
// Revision : 1.0
// ============================================================================
interface maxpool_sched_if #(
    parameter int IN_H = 14,
    parameter int IN_W = 14
);
    localparam int OUT_H = (IN_H + 1) / 2;
    localparam int OUT_W = (IN_W + 1) / 2;
    localparam int N_WIN = OUT_H * OUT_W;
    localparam int IDX_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [IDX_W-1:0] win_idx;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             pad_right;
    logic             pad_bottom;
    logic [7:0]       pool_in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_addr;
    logic [7:0]       out_data;

    modport master (
        output win_idx, win_row, win_col, pad_right, pad_bottom,
        output out_valid, out_addr, out_data,
        input  pool_in, out_ready
    );

    modport slave (
        input  win_idx, win_row, win_col, pad_right, pad_bottom,
        input  out_valid, out_addr, out_data,
        output pool_in, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_sched.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_sched
// Brief    : Walks every 2x2 pooling window in row-major order and streams the
//            registered pooled results out under a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module maxpool_sched #(
    parameter int IN_H = 14,
    parameter int IN_W = 14
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  start,
    output logic busy,
    output logic done,
    maxpool_sched_if.master bus
);
    localparam int OUT_H = (IN_H + 1) / 2;
    localparam int OUT_W = (IN_W + 1) / 2;
    localparam int N_WIN = OUT_H * OUT_W;
    localparam int IDX_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_WIN - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(OUT_W - 1);
    localparam bit               c_W_ODD    = (IN_W % 2) == 1;
    localparam bit               c_H_ODD    = (IN_H % 2) == 1;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_addr;
    logic [7:0]       r_out_data;

    logic w_slot_free;
    logic w_last_win;
    logic w_last_col;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_last_win  = (r_idx == c_LAST_IDX);
    assign w_last_col  = (r_col == c_LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_idx   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                c_RUN: begin
                    // Capture refills the slot, so a handshake here never drops valid.
                    if (w_slot_free) begin
                        r_out_data  <= bus.pool_in;
                        r_out_addr  <= r_idx;
                        r_out_valid <= 1'b1;
                        if (w_last_win) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                c_DRAIN: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_DONE;
                        r_idx       <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign done           = (r_state == c_DONE);
    assign bus.win_idx    = r_idx;
    assign bus.win_row    = r_row;
    assign bus.win_col    = r_col;
    assign bus.pad_right  = c_W_ODD && (r_col == c_LAST_COL);
    assign bus.pad_bottom = c_H_ODD && (r_row == c_LAST_ROW);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_data   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_sched
// Brief    : Scoreboard bench for maxpool_sched on 14x14, 7x7 and 2x3 maps.
// Revision : 1.0
// ============================================================================
module tb_maxpool_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start14, start7, start23;
    logic busy14, done14, busy7, done7, busy23, done23;
    logic bp;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    maxpool_sched_if #(.IN_H(14), .IN_W(14)) b14 ();
    maxpool_sched_if #(.IN_H(7),  .IN_W(7))  b7  ();
    maxpool_sched_if #(.IN_H(2),  .IN_W(3))  b23 ();

    maxpool_sched #(.IN_H(14), .IN_W(14)) u14 (
        .clk(clk), .rst(rst), .start(start14), .busy(busy14), .done(done14), .bus(b14));
    maxpool_sched #(.IN_H(7), .IN_W(7)) u7 (
        .clk(clk), .rst(rst), .start(start7), .busy(busy7), .done(done7), .bus(b7));
    maxpool_sched #(.IN_H(2), .IN_W(3)) u23 (
        .clk(clk), .rst(rst), .start(start23), .busy(busy23), .done(done23), .bus(b23));

    // Pool mux models: 14x14 returns idx+3, small maps fold the pad flags into the data.
    assign b14.pool_in = 8'(b14.win_idx) + 8'd3;
    assign b7.pool_in  = {b7.pad_right,  b7.pad_bottom,  6'(b7.win_idx)};
    assign b23.pool_in = {b23.pad_right, b23.pad_bottom, 6'(b23.win_idx)};

    logic [15:0] q14[$];
    logic [15:0] q7[$];
    logic [15:0] q23[$];

    int n_cmp = 0;
    int n_err = 0;
    int beats14 = 0, busy_cnt14 = 0, busy_last14 = 0, hs_last14 = 0;
    int done_cnt14 = 0, done_cyc14 = 0;
    int done_cnt7 = 0, done_cyc7 = 0, done_cnt23 = 0, done_cyc23 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] addr);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got beat addr %0d, expected no beat", name, addr);
    endtask

    // Monitor: compares every presented beat (including stalled ones) with the queue head.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (b14.out_valid) begin
                if (q14.size() == 0) unexpected("u14_beat", 32'(b14.out_addr));
                else begin
                    chk("u14_addr", 32'(b14.out_addr), 32'(q14[0][15:8]));
                    chk("u14_data", 32'(b14.out_data), 32'(q14[0][7:0]));
                    if (b14.out_ready) begin
                        void'(q14.pop_front());
                        beats14++;
                        hs_last14 = cyc;
                    end
                end
            end
            if (b7.out_valid) begin
                if (q7.size() == 0) unexpected("u7_beat", 32'(b7.out_addr));
                else begin
                    chk("u7_addr", 32'(b7.out_addr), 32'(q7[0][15:8]));
                    chk("u7_pad_data", 32'(b7.out_data), 32'(q7[0][7:0]));
                    if (b7.out_ready) void'(q7.pop_front());
                end
            end
            if (b23.out_valid) begin
                if (q23.size() == 0) unexpected("u23_beat", 32'(b23.out_addr));
                else begin
                    chk("u23_addr", 32'(b23.out_addr), 32'(q23[0][15:8]));
                    chk("u23_pad_data", 32'(b23.out_data), 32'(q23[0][7:0]));
                    if (b23.out_ready) void'(q23.pop_front());
                end
            end
            if (busy14) begin busy_cnt14++; busy_last14 = cyc; end
            if (done14) begin done_cnt14++; done_cyc14 = cyc; end
            if (done7)  begin done_cnt7++;  done_cyc7  = cyc; end
            if (done23) begin done_cnt23++; done_cyc23 = cyc; end
        end
    end

    // Sink ready for the 14x14 instance: 1,0,0,1 repeating while bp is set.
    initial begin
        bit [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        b14.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b14.out_ready = bp ? pat[ph % 4] : 1'b1;
            ph++;
        end
    end

    task automatic push14();
        for (int i = 0; i < 49; i++) q14.push_back({8'(i), 8'(i + 3)});
    endtask

    task automatic pulse_start14(output int k);
        @(posedge clk);
        #1 start14 = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        start14 = 1'b0;
    endtask

    task automatic wait_done14(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done14) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no done within %0d cycles, expected a done pulse", name, budget);
        end
    endtask

    initial begin
        int k, b0, d0, bc0, d7, d23;
        rst = 1'b1; start14 = 1'b0; start7 = 1'b0; start23 = 1'b0; bp = 1'b0;
        b7.out_ready = 1'b1;
        b23.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy14, 0);
        chk("rst_done", done14, 0);
        chk("rst_valid", b14.out_valid, 0);
        chk("rst_addr", 32'(b14.out_addr), 0);
        chk("rst_data", 32'(b14.out_data), 0);
        chk("rst_idx", 32'(b14.win_idx), 0);
        chk("rst_row_col", {b14.win_row, b14.win_col}, 0);
        chk("rst_small_busy", {busy7, busy23, done7, done23}, 0);

        // Full pass with extra start pulses at +5, +20 and in the done cycle.
        push14();
        b0 = beats14; d0 = done_cnt14; bc0 = busy_cnt14;
        pulse_start14(k);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 start14 = 1'b1; @(posedge clk); #1 start14 = 1'b0;
                repeat (14) @(posedge clk);
                #1 start14 = 1'b1; @(posedge clk); #1 start14 = 1'b0;
                repeat (30) @(posedge clk);
                #1 start14 = 1'b1; @(posedge clk); #1 start14 = 1'b0;
            end
        join_none
        wait_done14(200, "A_done_wait");
        repeat (6) @(negedge clk);
        chk("A_done_cycle", done_cyc14, k + 50);
        chk("A_done_count", done_cnt14 - d0, 1);
        chk("A_beats", beats14 - b0, 49);
        chk("A_busy_cycles", busy_cnt14 - bc0, 50);
        chk("A_busy_last", busy_last14, k + 49);
        chk("A_idle_after", busy14, 0);
        chk("A_queue_empty", q14.size(), 0);

        // Backpressure pass.
        bp = 1'b1;
        push14();
        b0 = beats14; d0 = done_cnt14;
        pulse_start14(k);
        wait_done14(400, "B_done_wait");
        repeat (3) @(negedge clk);
        bp = 1'b0;
        chk("B_beats", beats14 - b0, 49);
        chk("B_done_count", done_cnt14 - d0, 1);
        chk("B_done_after_hs", done_cyc14, hs_last14 + 1);
        chk("B_queue_empty", q14.size(), 0);

        // Reset twenty cycles into a pass.
        push14();
        pulse_start14(k);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("C_busy", busy14, 0);
        chk("C_done", done14, 0);
        chk("C_valid", b14.out_valid, 0);
        chk("C_addr", 32'(b14.out_addr), 0);
        chk("C_data", 32'(b14.out_data), 0);
        chk("C_win", {b14.win_idx, b14.win_row, b14.win_col}, 0);
        q14.delete();
        d0 = done_cnt14;
        repeat (5) @(negedge clk);
        chk("C_no_done", done_cnt14 - d0, 0);

        // Clean pass after the abort.
        push14();
        b0 = beats14; d0 = done_cnt14;
        pulse_start14(k);
        wait_done14(200, "D_done_wait");
        repeat (3) @(negedge clk);
        chk("D_done_cycle", done_cyc14, k + 50);
        chk("D_beats", beats14 - b0, 49);
        chk("D_done_count", done_cnt14 - d0, 1);
        chk("D_queue_empty", q14.size(), 0);

        // Odd 7x7 map and a 2x3 map run together.
        for (int i = 0; i < 16; i++)
            q7.push_back({8'(i), (i % 4) == 3, i >= 12, 6'(i)});
        for (int i = 0; i < 2; i++)
            q23.push_back({8'(i), i == 1, 1'b0, 6'(i)});
        d7 = done_cnt7; d23 = done_cnt23;
        @(posedge clk);
        #1 start7 = 1'b1; start23 = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        start7 = 1'b0; start23 = 1'b0;
        repeat (30) @(negedge clk);
        chk("S7_done_cycle", done_cyc7, k + 17);
        chk("S7_done_count", done_cnt7 - d7, 1);
        chk("S7_queue_empty", q7.size(), 0);
        chk("S23_done_cycle", done_cyc23, k + 3);
        chk("S23_done_count", done_cnt23 - d23, 1);
        chk("S23_queue_empty", q23.size(), 0);
        chk("S_idle_after", {busy7, busy23}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
